mem_lsu: RTL
============

// Module: mem_lsu
// PURPOSE
//   Load/store initiator for the mem pipeline stage. Accepts one load/store per handshake, checks alignment,
//   drives the memory block's mem_* request port until acknowledged, and captures read data.
//   Returns one result per request (data, destination register, fault code) to writeback via valid/ready.
//   Sits between the execute/mem pipeline registers and the unified memory block.
// PARAMETERS
//   ACK_TIMEOUT  255  cycles REQ may wait for mem_ack before faulting; 0 = wait forever
// PORTS
//   clk          in   1   clock, all state on posedge
//   reset_n      in   1   asynchronous active-low reset
//   ex_valid     in   1   request from pipeline valid
//   ex_ready     out  1   LSU can accept a request (high only in IDLE)
//   ex_addr      in   32  byte address
//   ex_write     in   1   1 = store, 0 = load
//   ex_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//   ex_width     in   2   00 byte, 01 half, 10/11 word
//   ex_extend    in   1   sign-extend load result
//   ex_rd        in   5   destination register tag, passed through
//   wb_valid     out  1   result valid
//   wb_ready     in   1   writeback consumes result
//   wb_data      out  32  load data; 0 for stores; faulting address on fault
//   wb_rd        out  5   tag of completed request
//   wb_store     out  1   completed request was a store
//   wb_fault     out  2   00 none, 01 misaligned, 10 ack timeout
//   mem_req      out  1   request to memory
//   mem_addr     out  32  request address
//   mem_write    out  1   request is a write
//   mem_data_in  out  32  write data (memory positions bytes itself)
//   mem_extend   out  1   sign-extend, to memory
//   mem_width    out  2   access width, to memory
//   mem_ack      in   1   memory accepted request this cycle
//   mem_data_out in   32  read data, valid the cycle after the ack cycle
// BEHAVIOUR
//   Reset (async, reset_n low): state IDLE; all outputs 0 except ex_ready=1; timeout counter 0.
//   Reset mid-operation drops mem_req immediately; the in-flight request is discarded, no wb result.
//   mem_* outputs and wb_* outputs are driven only from registers, never combinationally from ex_*.
//   FSM IDLE -> REQ | RESP; REQ -> DATA | RESP; DATA -> RESP; RESP -> IDLE.
//   IDLE: ex_ready=1. On ex_valid, latch addr/write/wdata/width/extend/rd.
//     Misaligned (width 01 and addr[0]=1; width 1x and addr[1:0]!=0): RESP, wb_fault=01,
//     wb_data=addr, no mem_req ever raised. Otherwise go to REQ.
//   REQ: mem_req=1; mem_* hold latched values, stable until ack. Counter increments each REQ cycle.
//     mem_ack & write: RESP with wb_data=0, wb_store=1. mem_ack & ~write: DATA.
//     No ack and counter == ACK_TIMEOUT-1 (ACK_TIMEOUT!=0): drop mem_req, RESP with wb_fault=10,
//     wb_data=addr. An ack in the same cycle as expiry wins (normal completion).
//   DATA: mem_req=0; register mem_data_out into wb_data (already extracted/extended by memory); -> RESP.
//   RESP: wb_valid=1, wb_* stable; on wb_ready go IDLE and clear wb_valid next cycle.
//     No new request accepted until back in IDLE (max one outstanding, no bypass).
//   Latency, no stalls: store done 2 cycles after accept (wb_valid 2nd edge);
//     load 3 cycles; misaligned 1 cycle.
//   ex_valid while not in IDLE is ignored (ex_ready=0); pipeline must hold it.
//   Width 11 behaves identically to 10 everywhere.
// TESTING
//   Load word: mem[0x100]=0xDEADBEEF, ex addr 0x100 w=10 rd=5 -> mem_req 1 cycle, wb_data=0xDEADBEEF, rd=5, 3 cycles.
//   Signed byte: mem[0x200]=0x00008000, addr 0x201 w=00 ext=1 -> wb_data=0xFFFFFF80; ext=0 -> 0x00000080.
//   Store half: addr 0x302 w=01 wdata=0x1234, then load word 0x300 -> upper half 0x1234, wb_store=1 & wb_data=0 on store.
//   Misaligned: addr 0x103 w=10 -> mem_req never asserts, wb_fault=01, wb_data=0x103 after 1 cycle.
//   Timeout: ACK_TIMEOUT=4, hold mem_ack=0 -> mem_req high exactly 4 cycles, then wb_fault=10, wb_data=addr.
//   Backpressure/reset: wb_ready=0 for 5 cycles holds wb_* stable, ex_ready=0; reset_n low in REQ -> mem_req 0 async, IDLE.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store initiator: latches one pipeline request, checks alignment, drives the memory request until
// acknowledged (or timed out) and returns one registered result per request over a valid/ready handshake.
module mem_lsu #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_addr,
    input  logic        ex_write,
    input  logic [31:0] ex_wdata,
    input  logic [1:0]  ex_width,
    input  logic        ex_extend,
    input  logic [4:0]  ex_rd,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_store,
    output logic [1:0]  wb_fault,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_data_in,
    output logic        mem_extend,
    output logic [1:0]  mem_width,
    input  logic        mem_ack,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0]  FAULT_NONE    = 2'b00;
    localparam logic [1:0]  FAULT_ALIGN   = 2'b01;
    localparam logic [1:0]  FAULT_TIMEOUT = 2'b10;
    localparam logic [31:0] CNT_LAST      = 32'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  width_q, width_d;
    logic        extend_q, extend_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_store_q, wb_store_d;
    logic [1:0]  wb_fault_q, wb_fault_d;
    logic        misaligned;

    // Width 11 is treated as a word access everywhere.
    assign misaligned = (ex_width == 2'b01 && ex_addr[0]) ||
                        (ex_width[1] && ex_addr[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        width_d    = width_q;
        extend_d   = extend_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        wb_store_d = wb_store_q;
        wb_fault_d = wb_fault_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    addr_d     = ex_addr;
                    write_d    = ex_write;
                    wdata_d    = ex_wdata;
                    width_d    = ex_width;
                    extend_d   = ex_extend;
                    rd_d       = ex_rd;
                    wb_store_d = ex_write;
                    cnt_d      = '0;
                    if (misaligned) begin
                        wb_fault_d = FAULT_ALIGN;
                        wb_data_d  = ex_addr;
                        state_d    = RESP;
                    end else begin
                        wb_fault_d = FAULT_NONE;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 32'd1;
                // An ack arriving on the expiry cycle still completes normally.
                if (mem_ack) begin
                    if (write_q) begin
                        wb_data_d = '0;
                        state_d   = RESP;
                    end else begin
                        state_d   = DATA;
                    end
                end else if (ACK_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    wb_fault_d = FAULT_TIMEOUT;
                    wb_data_d  = addr_q;
                    state_d    = RESP;
                end
            end
            DATA: begin
                wb_data_d = mem_data_out;
                state_d   = RESP;
            end
            RESP: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            width_q    <= '0;
            extend_q   <= 1'b0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_data_q  <= '0;
            wb_store_q <= 1'b0;
            wb_fault_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            width_q    <= width_d;
            extend_q   <= extend_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_data_q  <= wb_data_d;
            wb_store_q <= wb_store_d;
            wb_fault_q <= wb_fault_d;
        end
    end

    assign ex_ready    = (state_q == IDLE);
    assign wb_valid    = (state_q == RESP);
    assign wb_data     = wb_data_q;
    assign wb_rd       = rd_q;
    assign wb_store    = wb_store_q;
    assign wb_fault    = wb_fault_q;
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign mem_write   = write_q;
    assign mem_data_in = wdata_q;
    assign mem_extend  = extend_q;
    assign mem_width   = width_q;

endmodule
